// File: rtl/axi_sram_pkg.sv
// Shared types for the AXI4 SRAM target: burst/response encodings,
// FSM states and the per-beat address generator.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD_BEAT,
    WR_BEAT,
    WR_RESP
  } state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } burst_t;

  function automatic logic [63:0] next_addr(
    input logic [63:0] addr,
    input burst_t      req
  );
    logic [63:0] step;
    logic [63:0] mask;
    logic [63:0] res;
    step = 64'd1 << req.size;
    mask = (({56'd0, req.len} + 64'd1) << req.size) - 64'd1;
    unique case (1'b1)
      req.burst == BURST_INCR: res = addr + step;
      req.burst == BURST_WRAP:
        res = (addr & ~mask) | ((addr + step) & mask);
      default: res = addr;
    endcase
    return res;
  endfunction

  // Reserved burst type, illegal wrap length or oversize beat.
  function automatic logic bad_burst(
    input burst_t     req,
    input logic [2:0] max_size
  );
    logic bad_len;
    bad_len = !(req.len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (req.burst == BURST_WRAP && bad_len) ||
           (req.burst == 2'b11) ||
           (req.size > max_size);
  endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int AXI_USER_WIDTH = 1
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]         w_strb;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

endinterface

// File: rtl/axi_sram_slave_sram_array.sv
// Single-port byte-enabled synchronous SRAM, one-cycle read latency.
module sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     re,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 target backed by on-chip SRAM; one burst in flight,
// alternating read/write priority on simultaneous requests.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int AXI_DATA_WIDTH     = 32,
  parameter int AXI_ID_SLAVE_WIDTH = 3,
  parameter int AXI_USER_WIDTH     = 1,
  parameter int RAM_SIZE           = 65536,
  parameter int WAIT_STATES        = 0
) (
  input logic   clk,
  input logic   rst_n,
  AXI_BUS.slave slave
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int OFF_W = $clog2(RAM_SIZE);
  localparam int DEPTH = RAM_SIZE / BYTES;
  localparam logic [2:0] MAX_SIZE = 3'(LSB);
  localparam logic [2:0] WS       = 3'(WAIT_STATES);

  state_e state_q, state_d;

  logic                          rd_prio_q;
  logic [AXI_ID_SLAVE_WIDTH-1:0] id_q;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_ADDR_WIDTH-1:0]     addr_nx;
  burst_t                        req_q;
  burst_t                        ar_req;
  burst_t                        aw_req;
  logic                          err_q;
  logic                          wlast_err_q;
  logic [7:0]                    beat_q;
  logic [2:0]                    wait_q;
  logic                          rvalid_q;
  logic [AXI_DATA_WIDTH-1:0]     ram_q;

  logic idle, ar_rdy, aw_rdy;
  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic last_beat, rd_fire, ram_re, ram_we;

  assign idle   = state_q == IDLE;
  assign ar_rdy = idle && (!slave.aw_valid || rd_prio_q);
  assign aw_rdy = idle && (!slave.ar_valid || !rd_prio_q);

  assign ar_hs = slave.ar_valid && ar_rdy;
  assign aw_hs = slave.aw_valid && aw_rdy;
  assign r_hs  = rvalid_q && slave.r_ready;
  assign w_hs  = state_q == WR_BEAT && slave.w_valid;
  assign b_hs  = state_q == WR_RESP && slave.b_ready;

  assign last_beat = beat_q == req_q.len;
  assign rd_fire   = state_q == RD_BEAT && !rvalid_q
                  && wait_q == 3'd0;
  assign ram_re    = rd_fire && !err_q;
  assign ram_we    = w_hs && !err_q;

  assign ar_req = '{len:   slave.ar_len,
                    size:  slave.ar_size,
                    burst: slave.ar_burst};
  assign aw_req = '{len:   slave.aw_len,
                    size:  slave.aw_size,
                    burst: slave.aw_burst};

  assign addr_nx = AXI_ADDR_WIDTH'(
    next_addr(64'(addr_q), req_q));

  assign slave.ar_ready = ar_rdy;
  assign slave.aw_ready = aw_rdy;
  assign slave.w_ready  = state_q == WR_BEAT;

  assign slave.r_valid = rvalid_q;
  assign slave.r_id    = id_q;
  assign slave.r_last  = rvalid_q && last_beat;
  assign slave.r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
  assign slave.r_data  = (rvalid_q && !err_q) ? ram_q : '0;
  assign slave.r_user  = '0;

  assign slave.b_valid = state_q == WR_RESP;
  assign slave.b_id    = id_q;
  assign slave.b_resp  = (err_q || wlast_err_q)
                       ? RESP_SLVERR : RESP_OKAY;
  assign slave.b_user  = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs)      state_d = RD_BEAT;
        else if (aw_hs) state_d = WR_BEAT;
      end
      RD_BEAT: if (r_hs && last_beat) state_d = IDLE;
      WR_BEAT: if (w_hs && last_beat) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prio_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
      wlast_err_q <= 1'b0;
      beat_q      <= '0;
      wait_q      <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      // Priority flips only when both channels contend.
      if (idle && slave.ar_valid && slave.aw_valid)
        rd_prio_q <= !rd_prio_q;
      if (ar_hs) begin
        id_q   <= slave.ar_id;
        addr_q <= slave.ar_addr;
        req_q  <= ar_req;
        err_q  <= bad_burst(ar_req, MAX_SIZE);
        beat_q <= '0;
        wait_q <= WS;
      end else if (aw_hs) begin
        id_q        <= slave.aw_id;
        addr_q      <= slave.aw_addr;
        req_q       <= aw_req;
        err_q       <= bad_burst(aw_req, MAX_SIZE);
        wlast_err_q <= 1'b0;
        beat_q      <= '0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
      end else if (state_q == RD_BEAT && !rvalid_q) begin
        wait_q <= wait_q - 3'd1;
      end
      if (r_hs) begin
        rvalid_q <= 1'b0;
        addr_q   <= addr_nx;
        beat_q   <= beat_q + 8'd1;
        wait_q   <= WS;
      end
      if (w_hs) begin
        addr_q <= addr_nx;
        beat_q <= beat_q + 8'd1;
        if (slave.w_last != last_beat) wlast_err_q <= 1'b1;
      end
    end
  end

  sram_array #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk   (clk),
    .rst_n (rst_n),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (addr_q[OFF_W-1:LSB]),
    .be    (slave.w_strb),
    .wdata (slave.w_data),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed scoreboard bench for axi_sram_slave (32-bit data,
// 64 KiB, three wait states).
module tb_axi_sram_slave;

  localparam int WS = 3;
  localparam int FIX = 0;
  localparam int INC = 1;
  localparam int WRP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [2:0]  id;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic [2:0] id;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  logic [7:0] mem_m [65536];

  int          rd_len;
  int          w_len;
  logic [31:0] w_d0;
  logic [31:0] w_step;
  logic [3:0]  w_strb;
  int          w_mode;

  AXI_BUS #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .AXI_ID_WIDTH   (3),
    .AXI_USER_WIDTH (1)
  ) bus ();

  axi_sram_slave #(
    .AXI_ADDR_WIDTH     (32),
    .AXI_DATA_WIDTH     (32),
    .AXI_ID_SLAVE_WIDTH (3),
    .AXI_USER_WIDTH     (1),
    .RAM_SIZE           (65536),
    .WAIT_STATES        (WS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .slave (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic timeout(string tag);
    n_asserts++;
    n_fail++;
    $error("FAIL %s: timeout waiting on DUT", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nxt(logic [31:0] a,
    int len, int size, int burst);
    int unsigned step;
    int unsigned win;
    logic [31:0] base;
    step = 1 << size;
    if (burst == FIX) return a;
    if (burst == INC) return a + step;
    win  = (len + 1) * step;
    base = a - (a % win);
    return base + ((a - base + step) % win);
  endfunction

  function automatic bit is_bad(int len, int size, int burst);
    if (size > 2) return 1;
    if (burst == 3) return 1;
    if (burst == WRP &&
        !(len == 1 || len == 3 || len == 7 || len == 15))
      return 1;
    return 0;
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    int o;
    o = int'(a[15:0]) & 32'hFFFC;
    return {mem_m[o+3], mem_m[o+2], mem_m[o+1], mem_m[o]};
  endfunction

  task automatic ar_drive(logic [2:0] id, logic [31:0] addr,
    int len, int size, int burst);
    bit bad;
    logic [31:0] a;
    rexp_t e;
    bad = is_bad(len, size, burst);
    a = addr;
    for (int b = 0; b <= len; b++) begin
      e.data = bad ? 32'h0 : rd_word(a);
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (b == len);
      e.id   = id;
      rq.push_back(e);
      a = nxt(a, len, size, burst);
    end
    rd_len       = len;
    bus.ar_id    = id;
    bus.ar_addr  = addr;
    bus.ar_len   = 8'(len);
    bus.ar_size  = 3'(size);
    bus.ar_burst = 2'(burst);
    bus.ar_valid = 1'b1;
  endtask

  task automatic aw_drive(logic [2:0] id, logic [31:0] addr,
    int len, int size, int burst, logic [31:0] d0,
    logic [31:0] step, logic [3:0] strb, int mode);
    bit bad;
    logic [31:0] a;
    logic [31:0] d;
    int o;
    bexp_t e;
    bad = is_bad(len, size, burst);
    a = addr;
    for (int b = 0; b <= len; b++) begin
      d = d0 + step * 32'(b);
      o = int'(a[15:0]) & 32'hFFFC;
      if (!bad)
        for (int i = 0; i < 4; i++)
          if (strb[i]) mem_m[o+i] = d[8*i +: 8];
      a = nxt(a, len, size, burst);
    end
    e.resp = (bad || mode != 0) ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    w_len  = len;
    w_d0   = d0;
    w_step = step;
    w_strb = strb;
    w_mode = mode;
    bus.aw_id    = id;
    bus.aw_addr  = addr;
    bus.aw_len   = 8'(len);
    bus.aw_size  = 3'(size);
    bus.aw_burst = 2'(burst);
    bus.aw_valid = 1'b1;
  endtask

  task automatic ar_wait_hs();
    int n;
    n = 0;
    forever begin
      #1;
      if (bus.ar_ready) break;
      tick();
      n++;
      if (n > 60) begin
        timeout("ar_handshake");
        bus.ar_valid = 1'b0;
        return;
      end
    end
    tick();
    bus.ar_valid = 1'b0;
  endtask

  task automatic aw_wait_hs();
    int n;
    n = 0;
    forever begin
      #1;
      if (bus.aw_ready) break;
      tick();
      n++;
      if (n > 60) begin
        timeout("aw_handshake");
        bus.aw_valid = 1'b0;
        return;
      end
    end
    tick();
    bus.aw_valid = 1'b0;
  endtask

  task automatic r_collect(int nb, int stall_beat, int stall_n);
    int lat;
    int last_b;
    rexp_t e;
    last_b = (nb < 0) ? rd_len : nb - 1;
    for (int b = 0; b <= last_b; b++) begin
      lat = 0;
      while (!bus.r_valid && lat < 40) begin
        tick();
        lat++;
      end
      if (!bus.r_valid) begin
        timeout("r_valid");
        rq.delete();
        return;
      end
      chk("r_latency", 64'(lat), 64'(1 + WS));
      if (rq.size() == 0) begin
        timeout("r_scoreboard_empty");
        return;
      end
      e = rq.pop_front();
      chk("r_data", 64'(bus.r_data), 64'(e.data));
      chk("r_resp", 64'(bus.r_resp), 64'(e.resp));
      chk("r_last", 64'(bus.r_last), 64'(e.last));
      chk("r_id", 64'(bus.r_id), 64'(e.id));
      if (b == stall_beat) begin
        repeat (stall_n) begin
          tick();
          chk("stall_valid", 64'(bus.r_valid), 64'd1);
          chk("stall_data", 64'(bus.r_data), 64'(e.data));
          chk("stall_last", 64'(bus.r_last), 64'(e.last));
          chk("stall_resp", 64'(bus.r_resp), 64'(e.resp));
        end
      end
      bus.r_ready = 1'b1;
      tick();
      bus.r_ready = 1'b0;
    end
  endtask

  task automatic w_send();
    int n;
    for (int b = 0; b <= w_len; b++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = w_d0 + w_step * 32'(b);
      bus.w_strb  = w_strb;
      bus.w_last  = (w_mode == 0) ? (b == w_len) :
                    (w_mode == 1) ? (b == 0) : 1'b0;
      n = 0;
      forever begin
        #1;
        if (bus.w_ready) break;
        tick();
        n++;
        if (n > 60) begin
          timeout("w_ready");
          bus.w_valid = 1'b0;
          return;
        end
      end
      tick();
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic b_collect();
    bexp_t e;
    int n;
    chk("b_valid_next", 64'(bus.b_valid), 64'd1);
    n = 0;
    while (!bus.b_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bus.b_valid || bq.size() == 0) begin
      timeout("b_valid");
      bq.delete();
      return;
    end
    e = bq.pop_front();
    chk("b_resp", 64'(bus.b_resp), 64'(e.resp));
    chk("b_id", 64'(bus.b_id), 64'(e.id));
    repeat (2) tick();
    chk("b_hold", 64'(bus.b_valid), 64'd1);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    chk("b_drop", 64'(bus.b_valid), 64'd0);
  endtask

  task automatic do_write(logic [2:0] id, logic [31:0] addr,
    int len, int size, int burst, logic [31:0] d0,
    logic [31:0] step, logic [3:0] strb, int mode);
    aw_drive(id, addr, len, size, burst, d0, step, strb, mode);
    aw_wait_hs();
    w_send();
    b_collect();
  endtask

  task automatic do_read(logic [2:0] id, logic [31:0] addr,
    int len, int size, int burst);
    ar_drive(id, addr, len, size, burst);
    ar_wait_hs();
    r_collect(-1, -1, 0);
  endtask

  initial begin
    int n;
    bit rd_first;
    bus.aw_id = '0;  bus.aw_addr = '0; bus.aw_len = '0;
    bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_id = '0;  bus.ar_addr = '0; bus.ar_len = '0;
    bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
    bus.r_ready = 1'b0;

    repeat (3) tick();
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
    chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
    chk("rst_r_last", 64'(bus.r_last), 64'd0);
    chk("rst_r_data", 64'(bus.r_data), 64'd0);
    chk("rst_r_resp", 64'(bus.r_resp), 64'd0);
    chk("rst_b_resp", 64'(bus.b_resp), 64'd0);
    rst_n = 1'b1;
    tick();

    do_write(3'd1, 32'h1000_0010, 3, 2, INC,
             32'h1111_1111, 32'h1111_1111, 4'hF, 0);
    do_read(3'd2, 32'h1000_0010, 3, 2, INC);
    do_read(3'd3, 32'h1000_0018, 3, 2, WRP);

    for (int r = 0; r < 3; r++) begin
      rd_first = (r != 1);
      aw_drive(3'd4, 32'h0000_0600 + 32'(4 * r), 0, 2, INC,
               32'hC0DE_0000 + 32'(r), 32'h0, 4'hF, 0);
      ar_drive(3'd5, 32'h1000_0010 + 32'(4 * r), 0, 2, INC);
      #1;
      chk("arb_ar_ready", 64'(bus.ar_ready), 64'(rd_first));
      chk("arb_aw_ready", 64'(bus.aw_ready), 64'(!rd_first));
      if (rd_first) begin
        ar_wait_hs();
        r_collect(-1, -1, 0);
        aw_wait_hs();
        w_send();
        b_collect();
      end else begin
        aw_wait_hs();
        w_send();
        b_collect();
        ar_wait_hs();
        r_collect(-1, -1, 0);
      end
    end
    do_read(3'd6, 32'h0000_0600, 2, 2, INC);

    ar_drive(3'd7, 32'h1000_0010, 3, 2, INC);
    ar_wait_hs();
    r_collect(-1, 1, 5);

    do_write(3'd1, 32'h0000_0200, 0, 2, INC,
             32'h0, 32'h0, 4'hF, 0);
    do_write(3'd1, 32'h0000_0200, 0, 2, INC,
             32'hAABB_CCDD, 32'h0, 4'h5, 0);
    do_read(3'd2, 32'h0000_0200, 0, 2, INC);

    do_write(3'd3, 32'h0000_0700, 1, 2, INC,
             32'h7000_0001, 32'h1, 4'hF, 1);
    do_write(3'd3, 32'h0000_0708, 1, 2, INC,
             32'h7100_0001, 32'h1, 4'hF, 2);
    do_read(3'd4, 32'h0000_0700, 3, 2, INC);

    do_read(3'd5, 32'h1000_0010, 2, 2, WRP);
    do_read(3'd5, 32'h1000_0010, 0, 3, INC);
    do_write(3'd6, 32'h1000_0010, 2, 2, WRP,
             32'hDEAD_0000, 32'h1, 4'hF, 0);
    do_read(3'd6, 32'h1000_0010, 3, 2, INC);

    do_write(3'd7, 32'h0000_0800, 2, 2, FIX,
             32'h5500_0000, 32'h1, 4'hF, 0);
    do_read(3'd7, 32'h0000_0800, 1, 2, FIX);

    do_write(3'd2, 32'h2000_0900, 0, 2, INC,
             32'h1234_5678, 32'h0, 4'hF, 0);
    do_read(3'd2, 32'h0000_0900, 0, 2, INC);

    do_write(3'd0, 32'h0000_0A00, 7, 2, INC,
             32'hA000_0000, 32'h0101_0101, 4'hF, 0);
    ar_drive(3'd1, 32'h0000_0A00, 7, 2, INC);
    ar_wait_hs();
    r_collect(1, -1, 0);
    n = 0;
    while (!bus.r_valid && n < 40) begin
      tick();
      n++;
    end
    chk("rst_beat2_valid", 64'(bus.r_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_r_valid", 64'(bus.r_valid), 64'd0);
    chk("midrst_r_last", 64'(bus.r_last), 64'd0);
    chk("midrst_ar_ready", 64'(bus.ar_ready), 64'd1);
    rq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    do_read(3'd2, 32'h0000_0A08, 0, 2, INC);
    do_read(3'd3, 32'h0000_0A00, 7, 2, INC);

    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
